// File: rtl/neuron_pkg.sv
// Types and widths shared by the neuron and its training sample feeder.
// Pure declarations: no latency, no flow control.
package neuron_pkg;

   localparam int X_WIDTH = 7;
   localparam int T_WIDTH = 2;
   localparam int N_WIDTH = 32;

   typedef struct packed {
      logic signed [X_WIDTH-1:0] x1;
      logic signed [X_WIDTH-1:0] x2;
      logic signed [T_WIDTH-1:0] t;
   } sample_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_FEED,
      ST_DONE
   } feeder_state_t;

endpackage

// File: rtl/sample_memory.sv
// Training-set store with fill count, full flag and sticky overflow.
// Write lands on the next edge, read is combinational; writes into a full store are dropped.
module sample_memory #(
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr,
   input  logic                  clr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  full;

   assign full    = (count == DEPTH_C);
   assign rd_data = mem[rd_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (clr) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (wr) begin
         if (full) overflow <= 1'b1;
         else      count    <= count + 1'b1;
      end
   end

   // Contents survive reset; a zero count is what invalidates them.
   always_ff @(posedge clk) begin
      if (!rst && wr && !clr && !full)
         mem[count[ADDR_WIDTH-1:0]] <= wr_data;
   end

endmodule

// File: rtl/training_sample_feeder.sv
// Streams a stored training set to the neuron, one sample per ready rising edge, epoch after epoch.
// Next sample appears one cycle after the consume edge; ready is a level, only its rise advances.
module training_sample_feeder import neuron_pkg::*; #(
   parameter int DEPTH      = 512,
   parameter int ADDR_WIDTH = 9,
   parameter int X_WIDTH    = neuron_pkg::X_WIDTH,
   parameter int T_WIDTH    = neuron_pkg::T_WIDTH,
   parameter int N_WIDTH    = neuron_pkg::N_WIDTH,
   parameter int MAX_EPOCHS = 64
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic signed [X_WIDTH-1:0] wr_x1,
   input  logic signed [X_WIDTH-1:0] wr_x2,
   input  logic signed [T_WIDTH-1:0] wr_t,
   input  logic                      clear,
   input  logic                      go,
   input  logic                      ready_to_get_data,
   input  logic                      done,
   output logic                      start,
   output logic [N_WIDTH-1:0]        n_bus,
   output logic signed [X_WIDTH-1:0] x1_bus,
   output logic signed [X_WIDTH-1:0] x2_bus,
   output logic signed [T_WIDTH-1:0] t_bus,
   output logic                      busy,
   output logic                      finished,
   output logic                      timeout,
   output logic                      overflow,
   output logic [15:0]               epoch_count
);

   localparam int          DW    = 2*X_WIDTH + T_WIDTH;
   localparam logic [15:0] MAX_E = 16'(MAX_EPOCHS);

   feeder_state_t         state;
   logic [ADDR_WIDTH:0]   idx;
   logic [ADDR_WIDTH:0]   next_idx;
   logic [ADDR_WIDTH:0]   count;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic [DW-1:0]         rd_data;
   logic                  ready_q;
   logic                  consume;
   logic                  wrap;
   logic                  in_idle;
   logic                  launch;

   assign in_idle  = (state == ST_IDLE);
   assign consume  = ready_to_get_data & ~ready_q;
   assign wrap     = (idx == count - 1'b1);
   assign next_idx = wrap ? '0 : idx + 1'b1;
   // Outside FEED the read port points at sample 0 so a launch can load it directly.
   assign rd_addr  = (state == ST_FEED) ? next_idx[ADDR_WIDTH-1:0] : '0;
   assign launch   = go && ((in_idle && count != '0) || state == ST_DONE);

   sample_memory #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DW)
   ) u_mem (
      .clk      (clk),
      .rst      (rst),
      .wr       (wr_en & in_idle),
      .clr      (clear & in_idle),
      .wr_data  ({wr_x1, wr_x2, wr_t}),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .count    (count),
      .overflow (overflow)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         idx         <= '0;
         ready_q     <= 1'b0;
         start       <= 1'b0;
         n_bus       <= '0;
         x1_bus      <= '0;
         x2_bus      <= '0;
         t_bus       <= '0;
         busy        <= 1'b0;
         finished    <= 1'b0;
         timeout     <= 1'b0;
         epoch_count <= '0;
      end else begin
         ready_q <= ready_to_get_data;
         start   <= 1'b0;
         if (launch) begin
            state                    <= ST_START;
            start                    <= 1'b1;
            n_bus                    <= N_WIDTH'(count);
            {x1_bus, x2_bus, t_bus}  <= rd_data;
            idx                      <= '0;
            epoch_count              <= '0;
            busy                     <= 1'b1;
            finished                 <= 1'b0;
            timeout                  <= 1'b0;
         end else begin
            case (state)
               ST_START: state <= ST_FEED;
               ST_FEED: begin
                  // done outranks a coincident consume: the sample does not advance.
                  if (done) begin
                     state    <= ST_DONE;
                     busy     <= 1'b0;
                     finished <= 1'b1;
                  end else if (consume) begin
                     idx                     <= next_idx;
                     {x1_bus, x2_bus, t_bus} <= rd_data;
                     if (wrap) begin
                        epoch_count <= epoch_count + 16'd1;
                        if (epoch_count + 16'd1 == MAX_E) begin
                           state    <= ST_DONE;
                           busy     <= 1'b0;
                           finished <= 1'b1;
                           timeout  <= 1'b1;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/training_sample_feeder.md
Name: training_sample_feeder

Overview:
- Synthesizable supplier side of the neuron training interface.
- Stores a training set of (x1, x2, t) samples and launches training with a one-cycle start pulse plus the sample count.
- Streams samples onto the x1/x2/t buses, one per rising edge of ready_to_get_data, wrapping epoch after epoch until the neuron raises done.
- Replaces bench-side file feeding so the neuron can be trained on-chip.

Parameters:
- DEPTH, 512, maximum stored samples.
- ADDR_WIDTH, 9, log2(DEPTH).
- X_WIDTH, 7, signed width of x1 and x2.
- T_WIDTH, 2, signed width of target t.
- N_WIDTH, 32, width of n_bus.
- MAX_EPOCHS, 64, epoch limit before forced stop; 16-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write one sample (IDLE only).
- wr_x1  in  X_WIDTH  signed sample x1.
- wr_x2  in  X_WIDTH  signed sample x2.
- wr_t  in  T_WIDTH  signed target.
- clear  in  1  empty the stored set (IDLE only).
- go  in  1  begin training.
- ready_to_get_data  in  1  neuron requests next sample (level).
- done  in  1  neuron training complete (level).
- start  out  1  one-cycle start pulse to neuron.
- n_bus  out  N_WIDTH  sample count, zero-extended.
- x1_bus  out  X_WIDTH  current x1.
- x2_bus  out  X_WIDTH  current x2.
- t_bus  out  T_WIDTH  current t.
- busy  out  1  high in START/FEED.
- finished  out  1  high in DONE.
- timeout  out  1  DONE reached via MAX_EPOCHS.
- overflow  out  1  sticky: write attempted while full.
- epoch_count  out  16  completed epochs.

Behaviour:
- Reset (clk edge with rst=1): state IDLE; all outputs 0; count=0, idx=0. Memory contents are not cleared, but count=0 makes them invalid. Reset mid-operation aborts immediately, with no further start pulse or bus update.
- States: IDLE, START, FEED, DONE.
- IDLE:
  - wr_en with count<DEPTH writes mem[count] and increments count.
  - wr_en with count==DEPTH leaves memory and count unchanged and sets overflow.
  - clear sets count=0 and overflow=0. clear wins over a simultaneous wr_en.
  - go with count>0 goes to START; go with count==0 is ignored.
- START (exactly 1 cycle):
  - start=1, n_bus=count, x1/x2/t_bus=mem[0], idx=0, epoch_count=0.
  - Next state FEED; start returns to 0.
- FEED:
  - Buses hold mem[idx].
  - Consume event = rising edge of ready_to_get_data (ready & ~ready_q; ready_q is registered and reset to 0). Holding ready high gives one consume only.
  - On consume, at the next edge: idx = (idx==count-1) ? 0 : idx+1, and buses show the new sample. On wrap, epoch_count increments.
  - done=1 goes to DONE, and takes priority over a simultaneous consume (no advance).
  - If epoch_count reaches MAX_EPOCHS after a wrap, go to DONE with timeout=1.
- DONE:
  - finished=1; buses, n_bus and epoch_count hold their values.
  - go returns to START (retrain, same set).
  - wr_en and clear are ignored outside IDLE. rst is the only way back to IDLE.
- Memory: register array with combinational read; sample-to-bus latency is 1 cycle after the consume edge.
- Widths: n_bus = zero-extended count. idx/count use ADDR_WIDTH+1 bits so count==DEPTH is representable.

Decomposition:
- Package neuron_pkg:
  - X_WIDTH, T_WIDTH, N_WIDTH constants shared with the neuron.
  - Signed sample struct typedef {x1, x2, t}.
  - feeder_state_t enum.
- Sub-module sample_memory:
  - DEPTH×(2·X_WIDTH+T_WIDTH) array, synchronous write, combinational read.
  - Owns the count and full flag.

Test Plan:
- Load (5,-3,1), (-16,-16,-1), (2,7,1); go → start high exactly 1 cycle, n_bus=3, x1_bus=5 in FEED.
- Three ready rising edges → buses become (-16,-16,-1), (2,7,1), then (5,-3,1). epoch_count=1 after the third edge.
- Ready held high 5 cycles → exactly one advance. done asserted in the same cycle as a ready rise → no advance, finished=1 next cycle.
- DEPTH=4: 5 writes → count=4, overflow=1, mem[3] unchanged. clear → overflow=0. go with count=0 → stays IDLE, start never asserts.
- MAX_EPOCHS=2, 2 samples, done never raised → after the 4th consume: finished=1, timeout=1, epoch_count=2.
- rst asserted mid-FEED → next cycle all outputs 0 and state IDLE. A subsequent go without a reload is ignored (count=0).
